// File: rtl/core_csr_pkg.sv
// Shared Zicsr definitions: funct3 opcodes, sequencer state encoding and
// the read-only CSR address predicate. Imported by decode, the CSR file and
// core_csr_access.
package core_csr_pkg;

  // funct3 encodings of the Zicsr instructions (instr[14:12]).
  // Bit 2 selects the immediate form; bits [1:0] select the operation.
  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_t;

  // addr[11:10] == 2'b11 marks the read-only CSR space.
  function automatic logic csr_addr_is_ro(input logic [11:0] addr);
    return (addr[11:10] == 2'b11);
  endfunction

endpackage

// File: rtl/core_csr_access.sv
// Purpose: sequences one Zicsr instruction: read CSR, compute RW/RS/RC value,
//   issue at most one write strobe, return the old value and rd to writeback.
// Latency: accept = cycle 0; READ cycle 1, WRITE cycle 2, RSP_VALID cycle 3
//   (cycle 2 without write, cycle 1 when illegal).
// Backpressure: RSP_READY low holds RESP with stable outputs; REQ_READY is
//   high only in IDLE, so requests never overlap.
// Ports: REQ_* request from execute (valid/ready), CSR_* combinational-read /
//   single-strobe-write port to the CSR file, RSP_* result to writeback.
module core_csr_access
  import core_csr_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [11:0] REQ_ADDR,
  input  logic [4:0]  REQ_RS1,
  input  logic [31:0] REQ_RS1_VAL,
  input  logic [4:0]  REQ_RD,
  output logic [11:0] CSR_ADDR,
  input  logic [31:0] CSR_RDATA,
  output logic [31:0] CSR_WDATA,
  output logic        CSR_WE,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [4:0]  RSP_RD,
  output logic [31:0] RSP_DATA,
  output logic        RSP_ILLEGAL
);

  csr_state_t state_q, state_d;

  // Request decode, evaluated on the accept cycle only.
  logic [1:0]  req_op;
  logic        req_wr_intent;
  logic        req_illegal;
  logic [31:0] req_operand;

  // Instruction latches. Only funct3[1:0] is kept: the immediate/register
  // choice is already folded into the latched operand.
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [4:0]  rd_q;
  logic [31:0] operand_q;
  logic        wr_q;
  logic        illegal_q;
  logic [31:0] old_q;

  logic        accept;
  logic [31:0] new_val;

  assign req_op        = REQ_FUNCT3[1:0];
  // Set/clear with rs1 (or zimm) == 0 must not write, so read-only CSRs
  // can still be read with CSRRS/CSRRC.
  assign req_wr_intent = (req_op == CSRRW[1:0]) || (REQ_RS1 != 5'd0);
  assign req_illegal   = (req_op == 2'b00) ||
                         (req_wr_intent && csr_addr_is_ro(REQ_ADDR));
  assign req_operand   = REQ_FUNCT3[2] ? {27'b0, REQ_RS1} : REQ_RS1_VAL;

  assign accept = REQ_VALID && (state_q == ST_IDLE);
  assign RSP_RD = rd_q;

  always_comb begin
    new_val = 32'b0;
    case (op_q)
      CSRRW[1:0]: new_val = operand_q;
      CSRRS[1:0]: new_val = old_q | operand_q;
      CSRRC[1:0]: new_val = old_q & ~operand_q;
      default:    new_val = 32'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q      <= 2'b0;
      addr_q    <= 12'b0;
      rd_q      <= 5'b0;
      operand_q <= 32'b0;
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
      old_q     <= 32'b0;
    end else if (accept) begin
      op_q      <= req_op;
      addr_q    <= REQ_ADDR;
      rd_q      <= REQ_RD;
      operand_q <= req_operand;
      wr_q      <= req_wr_intent;
      illegal_q <= req_illegal;
      old_q     <= 32'b0;
    end else if (state_q == ST_READ) begin
      old_q     <= CSR_RDATA;
    end
  end

  // All CSR-side and response outputs decode from state alone, so an async
  // reset removes CSR_WE and RSP_VALID without waiting for a clock edge.
  always_comb begin
    state_d     = state_q;
    REQ_READY   = 1'b0;
    CSR_ADDR    = 12'b0;
    CSR_WDATA   = 32'b0;
    CSR_WE      = 1'b0;
    RSP_VALID   = 1'b0;
    RSP_DATA    = 32'b0;
    RSP_ILLEGAL = 1'b0;
    case (state_q)
      ST_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          state_d = req_illegal ? ST_RESP : ST_READ;
        end
      end
      ST_READ: begin
        CSR_ADDR = addr_q;
        state_d  = wr_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        CSR_ADDR  = addr_q;
        CSR_WE    = 1'b1;
        CSR_WDATA = new_val;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        RSP_VALID   = 1'b1;
        RSP_DATA    = illegal_q ? 32'b0 : old_q;
        RSP_ILLEGAL = illegal_q;
        if (RSP_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
